// File: rtl/updown_counter_fsm_pkg.sv
// Shared definitions for the up/down counter: direction-state encodings
// and the state-vector width.
package updown_counter_fsm_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DN   = 2'b10
  } state_e;

  function automatic logic is_counting(input state_e st);
    return (st == ST_UP) || (st == ST_DN);
  endfunction

endpackage

// File: rtl/register_sr.sv
// WIDTH-bit D register with synchronous active-high reset; holds the count.
module register_sr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (srst_i) begin
      q_o <= '0;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/updown_counter_fsm.sv
// Bidirectional counter steered by an IDLE/UP/DOWN state machine, with
// parallel load, stop, wrap-or-saturate ends and a registered terminal-count pulse.
module updown_counter_fsm
  import updown_counter_fsm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start_up,
  input  logic             start_dn,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             dir_up,
  output logic             tc
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             at_end;
  logic             illegal;

  always_comb begin
    count_d = q;
    state_d = state_q;
    tc_d    = 1'b0;
    at_end  = 1'b0;
    illegal = 1'b0;

    // Step from the current state; requests seen this cycle act on the state only.
    case (state_q)
      ST_IDLE: ;
      ST_UP: begin
        if (q == CNT_MAX) begin
          at_end  = 1'b1;
          count_d = WRAP ? '0 : q;
        end else begin
          count_d = q + CNT_ONE;
          tc_d    = (q == CNT_MAX - CNT_ONE);
        end
      end
      ST_DN: begin
        if (q == '0) begin
          at_end  = 1'b1;
          count_d = WRAP ? CNT_MAX : q;
        end else begin
          count_d = q - CNT_ONE;
          tc_d    = (q == CNT_ONE);
        end
      end
      default: illegal = 1'b1;
    endcase

    if (load) begin
      count_d = d;
      tc_d    = 1'b0;
    end else if (stop) begin
      count_d = q;
      tc_d    = 1'b0;
    end

    if (illegal || stop) begin
      state_d = ST_IDLE;
    end else if (start_up) begin
      state_d = ST_UP;
    end else if (start_dn) begin
      state_d = ST_DN;
    end else if (at_end && !WRAP && !load) begin
      state_d = ST_IDLE;
    end
  end

  // busy/dir_up decode the next state so they move on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      dir_up  <= 1'b0;
      tc      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= is_counting(state_d);
      dir_up  <= (state_d == ST_UP);
      tc      <= tc_d;
    end
  end

  register_sr #(
    .WIDTH(WIDTH)
  ) u_count (
    .clk   (clk),
    .srst_i(reset),
    .d_i   (count_d),
    .q_o   (q)
  );

endmodule

// File: tb/tb_updown_counter_fsm.sv
// Scoreboard bench: drives a wrapping and a saturating instance with the same
// stimulus; hand-derived expectations are queued per vector and checked one edge later.
module tb_updown_counter_fsm;

  localparam int W = 0;  // WRAP=1 instance
  localparam int S = 1;  // WRAP=0 instance

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] d = 8'h00;
  logic       start_up = 1'b0;
  logic       start_dn = 1'b0;
  logic       stop = 1'b0;

  logic [7:0] q_w, q_s;
  logic       busy_w, busy_s, dir_w, dir_s, tc_w, tc_s;

  typedef struct {
    int         due;
    int         idx;
    int         dut;
    logic [7:0] q;
    logic       busy;
    logic       dir_up;
    logic       tc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_m;
  int   cyc = 0;
  int   n_pushed = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  updown_counter_fsm #(.WIDTH(8), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .load(load), .d(d),
    .start_up(start_up), .start_dn(start_dn), .stop(stop),
    .q(q_w), .busy(busy_w), .dir_up(dir_w), .tc(tc_w)
  );

  updown_counter_fsm #(.WIDTH(8), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .load(load), .d(d),
    .start_up(start_up), .start_dn(start_dn), .stop(stop),
    .q(q_s), .busy(busy_s), .dir_up(dir_s), .tc(tc_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      logic [7:0] oq;
      logic       ob, od, ot;
      e_m = exp_q.pop_front();
      oq = (e_m.dut == S) ? q_s    : q_w;
      ob = (e_m.dut == S) ? busy_s : busy_w;
      od = (e_m.dut == S) ? dir_s  : dir_w;
      ot = (e_m.dut == S) ? tc_s   : tc_w;
      $display("txn %0d dut%0d q=%02h busy=%b dir_up=%b tc=%b", e_m.idx, e_m.dut, oq, ob, od, ot);
      check($sformatf("q#%0d", e_m.idx),      32'(oq), 32'(e_m.q));
      check($sformatf("busy#%0d", e_m.idx),   32'(ob), 32'(e_m.busy));
      check($sformatf("dir_up#%0d", e_m.idx), 32'(od), 32'(e_m.dir_up));
      check($sformatf("tc#%0d", e_m.idx),     32'(ot), 32'(e_m.tc));
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic vec(input int dut, input logic rst, input logic ld, input logic [7:0] dv,
                     input logic su, input logic sd, input logic sp,
                     input logic [7:0] eq, input logic eb, input logic ed, input logic et);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    load     = ld;
    d        = dv;
    start_up = su;
    start_dn = sd;
    stop     = sp;
    e.due    = cyc + 1;
    e.idx    = n_pushed;
    e.dut    = dut;
    e.q      = eq;
    e.busy   = eb;
    e.dir_up = ed;
    e.tc     = et;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  initial begin
    // reset then idle
    vec(W, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    vec(S, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) vec(W, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);

    // load FD, count up through MAX and wrap
    vec(W, 0, 1, 8'hFD, 0, 0, 0, 8'hFD, 0, 0, 0);
    vec(W, 0, 0, 8'h00, 1, 0, 0, 8'hFD, 1, 1, 0);
    vec(W, 0, 0, 8'h00, 0, 0, 0, 8'hFE, 1, 1, 0);
    vec(W, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 1, 1, 1);
    vec(W, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0);
    vec(W, 0, 0, 8'h00, 0, 0, 0, 8'h01, 1, 1, 0);
    vec(W, 0, 0, 8'h00, 0, 0, 1, 8'h01, 0, 0, 0);
    vec(W, 0, 0, 8'h00, 0, 0, 0, 8'h01, 0, 0, 0);

    // count down across zero, then stop
    vec(W, 0, 1, 8'h02, 0, 0, 0, 8'h02, 0, 0, 0);
    vec(W, 0, 0, 8'h00, 0, 1, 0, 8'h02, 1, 0, 0);
    vec(W, 0, 0, 8'h00, 0, 0, 0, 8'h01, 1, 0, 0);
    vec(W, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1);
    vec(W, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 1, 0, 0);
    vec(W, 0, 0, 8'h00, 0, 0, 1, 8'hFF, 0, 0, 0);
    vec(W, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 0, 0, 0);

    // simultaneous requests
    vec(W, 0, 0, 8'h00, 1, 1, 0, 8'hFF, 1, 1, 0);
    vec(W, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0);
    vec(W, 0, 1, 8'h55, 0, 0, 1, 8'h55, 0, 0, 0);
    vec(W, 0, 0, 8'h00, 0, 0, 0, 8'h55, 0, 0, 0);

    // reset mid-count
    vec(W, 0, 1, 8'h3E, 0, 0, 0, 8'h3E, 0, 0, 0);
    vec(W, 0, 0, 8'h00, 1, 0, 0, 8'h3E, 1, 1, 0);
    vec(W, 0, 0, 8'h00, 0, 0, 0, 8'h3F, 1, 1, 0);
    vec(W, 0, 0, 8'h00, 0, 0, 0, 8'h40, 1, 1, 0);
    vec(W, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) vec(W, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);

    // loading an end value does not pulse tc
    vec(W, 0, 1, 8'hFF, 0, 0, 0, 8'hFF, 0, 0, 0);
    vec(W, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);

    // saturation up (WRAP=0)
    vec(S, 0, 1, 8'hFE, 0, 0, 0, 8'hFE, 0, 0, 0);
    vec(S, 0, 0, 8'h00, 1, 0, 0, 8'hFE, 1, 1, 0);
    vec(S, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 1, 1, 1);
    vec(S, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 0, 0, 0);
    vec(S, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 0, 0, 0);

    // saturation down (WRAP=0)
    vec(S, 0, 1, 8'h01, 0, 0, 0, 8'h01, 0, 0, 0);
    vec(S, 0, 0, 8'h00, 0, 1, 0, 8'h01, 1, 0, 0);
    vec(S, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1);
    vec(S, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    vec(S, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) check("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
